// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: walks x through minterms 0..15, samples y_in after a settle
// window, and compares the captured table against a latched expected table.
module tt_sweep_capture #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_tt,
    input  logic        y_in,
    output logic [3:0]  x,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_mis,
    output logic [4:0]  ones_cnt
);

    localparam int unsigned TT_W   = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned HOLD_W = 4;
    localparam logic [HOLD_W-1:0] SETTLE_C = HOLD_W'(SETTLE);
    localparam logic [IDX_W-1:0]  LAST_X   = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

    state_t              state, state_d;
    logic [HOLD_W-1:0]   hcnt, hcnt_d;
    logic [TT_W-1:0]     exp_q, exp_d;
    logic [IDX_W-1:0]    x_d, first_d;
    logic [TT_W-1:0]     tt_d;
    logic [CNT_W-1:0]    mis_d, ones_d;
    logic                match_d, done_d, busy_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hcnt         <= '0;
            exp_q        <= '0;
            x            <= '0;
            tt           <= '0;
            mismatch_cnt <= '0;
            ones_cnt     <= '0;
            first_mis    <= '0;
            match        <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            hcnt         <= hcnt_d;
            exp_q        <= exp_d;
            x            <= x_d;
            tt           <= tt_d;
            mismatch_cnt <= mis_d;
            ones_cnt     <= ones_d;
            first_mis    <= first_d;
            match        <= match_d;
            done         <= done_d;
            busy         <= busy_d;
        end
    end

    // Next-state and datapath update; FINISH accepts start so sweeps can run back to back
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        exp_d   = exp_q;
        x_d     = x;
        tt_d    = tt;
        mis_d   = mismatch_cnt;
        ones_d  = ones_cnt;
        first_d = first_mis;
        match_d = match;
        done_d  = 1'b0;

        unique case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_d = HOLD;
                    exp_d   = exp_tt;
                    tt_d    = '0;
                    mis_d   = '0;
                    ones_d  = '0;
                    first_d = '0;
                    match_d = 1'b0;
                    x_d     = '0;
                    hcnt_d  = '0;
                end else if (state == FINISH) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    match_d = 1'b0;
                end else if (hcnt == SETTLE_C) begin
                    tt_d[x] = y_in;
                    ones_d  = ones_cnt + CNT_W'(y_in);
                    if (y_in != exp_q[x]) begin
                        if (mismatch_cnt == '0) begin
                            first_d = x;
                        end
                        mis_d = mismatch_cnt + CNT_W'(1);
                    end
                    if (x == LAST_X) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        match_d = (mis_d == '0);
                    end else begin
                        x_d    = x + IDX_W'(1);
                        hcnt_d = '0;
                    end
                end else begin
                    hcnt_d = hcnt + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
